// File: rtl/pipe_spawner.sv
// pipe_spawner: four-lane scrolling pipe field with LFSR gap placement and tightening gap.
// Pipes scroll one px per frame while playing, respawn at the right edge, and freeze on death.
module pipe_spawner #(
    parameter int          SPACING     = 200,
    parameter int          PIPE_HALF_W = 30,
    parameter int          SPEED       = 1,
    parameter int          GAP_INIT    = 80,
    parameter int          GAP_FLOOR   = 40,
    parameter int          GAP_STEP    = 2,
    parameter int          GAP_BASE    = 112,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             gameOn,
    input  logic             ded,
    output logic [3:0][12:0] pipeX,
    output logic [3:0][12:0] pipeWidth,
    output logic [3:0][12:0] pipeGapSize,
    output logic [3:0][12:0] pipeGapLocation
);
    typedef enum logic [1:0] {IDLE, SCROLL, FROZEN} state_t;

    localparam logic [12:0] SPD   = 13'(SPEED);
    localparam logic [12:0] WRAP  = 13'(4 * SPACING - SPEED);
    localparam logic [12:0] FLOOR = 13'(GAP_FLOOR);
    localparam logic [12:0] STEP  = 13'(GAP_STEP);
    localparam logic [12:0] BASE  = 13'(GAP_BASE);

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q;
    logic [12:0]      gap_q, gap_d;
    logic [3:0][12:0] x_q, x_d, gs_q, gs_d, gl_q, gl_d;
    logic             move;

    assign pipeX           = x_q;
    assign pipeGapSize     = gs_q;
    assign pipeGapLocation = gl_q;
    assign pipeWidth       = {4{13'(PIPE_HALF_W)}};

    always_comb begin
        state_d = (ded || state_q == FROZEN) ? FROZEN :
                  (state_q == SCROLL || gameOn) ? SCROLL : IDLE;
        move    = state_q == SCROLL && !ded && gameOn && frame_tick;
        x_d     = x_q;
        gs_d    = gs_q;
        gl_d    = gl_q;
        gap_d   = gap_q;
        // lanes are walked in index order so multiple respawns each take one gap step
        for (int i = 0; i < 4; i++) begin
            if (move) begin
                if (x_q[i] >= SPD) begin
                    x_d[i] = x_q[i] - SPD;
                end else begin
                    x_d[i]  = x_q[i] + WRAP;
                    gl_d[i] = BASE + {5'b0, lfsr_q[7:0]};
                    gap_d   = (gap_d >= FLOOR + STEP) ? gap_d - STEP : FLOOR;
                    gs_d[i] = gap_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            gap_q   <= 13'(GAP_INIT);
            for (int i = 0; i < 4; i++) begin
                x_q[i]  <= 13'(640 + PIPE_HALF_W + i * SPACING);
                gs_q[i] <= 13'(GAP_INIT);
                gl_q[i] <= 13'd240;
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            gap_q   <= gap_d;
            x_q     <= x_d;
            gs_q    <= gs_d;
            gl_q    <= gl_d;
        end
    end
endmodule

// File: tb/tb_pipe_spawner.sv
// tb_pipe_spawner: directed checks of scrolling, respawn, gap tightening, freeze and async reset.
module tb_pipe_spawner;
    logic             clk = 0;
    logic             Reset_n = 0;
    logic             frame_tick = 0;
    logic             gameOn = 0;
    logic             ded = 0;
    logic [3:0][12:0] pipeX, pipeWidth, pipeGapSize, pipeGapLocation;

    int          errors = 0;
    int          checks = 0;
    int          ex[4], egs[4], egl[4];
    int          egap, resp, last_lane;
    logic [15:0] m_lfsr;
    logic [7:0]  byte_s;

    pipe_spawner dut (
        .clk(clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .gameOn(gameOn), .ded(ded),
        .pipeX(pipeX), .pipeWidth(pipeWidth), .pipeGapSize(pipeGapSize),
        .pipeGapLocation(pipeGapLocation)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge Reset_n)
        if (!Reset_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ex[i] = 670 + 200 * i; egs[i] = 80; egl[i] = 240;
        end
        egap = 80; resp = 0; last_lane = -1;
    endtask

    task automatic model_tick();
        last_lane = -1;
        for (int i = 0; i < 4; i++) begin
            if (ex[i] >= 1) ex[i] = ex[i] - 1;
            else begin
                ex[i] = ex[i] + 799;
                egl[i] = 112 + byte_s;
                egap = (egap >= 42) ? egap - 2 : 40;
                egs[i] = egap;
                resp++;
                last_lane = i;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_x"}, pipeX[i], ex[i]);
            check({tag, "_w"}, pipeWidth[i], 30);
            check({tag, "_gs"}, pipeGapSize[i], egs[i]);
            check({tag, "_gl"}, pipeGapLocation[i], egl[i]);
        end
    endtask

    task automatic tick(input bit moving);
        @(negedge clk);
        frame_tick = 1;
        byte_s = m_lfsr[7:0];
        if (moving) model_tick();
        @(negedge clk);
        frame_tick = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset");
        Reset_n = 1;
        for (int k = 0; k < 10; k++) tick(0);
        chk_all("idle");

        gameOn = 1;
        @(negedge clk);
        @(negedge clk);
        frame_tick = 1;
        byte_s = m_lfsr[7:0];
        model_tick();
        check("pre_edge", pipeX[0], 670);
        @(posedge clk);
        #1 check("post_edge", pipeX[0], 669);
        @(negedge clk);
        frame_tick = 0;
        repeat (3) @(negedge clk);
        check("no_tick_hold", pipeX[0], 669);
        for (int k = 0; k < 4; k++) tick(1);
        check("five_ticks_x0", pipeX[0], 665);
        check("five_ticks_x3", pipeX[3], 1265);
        chk_all("five");

        for (int k = 0; k < 665; k++) tick(1);
        check("lane0_at_zero", pipeX[0], 0);
        tick(1);
        check("respawn_x", pipeX[0], 799);
        check("respawn_gs", pipeGapSize[0], 78);
        check("respawn_gl", pipeGapLocation[0], 112 + byte_s);
        check("respawn_gl_range", (pipeGapLocation[0] >= 112 && pipeGapLocation[0] <= 367), 1);
        for (int i = 1; i < 4; i++) check("other_gs", pipeGapSize[i], 80);
        chk_all("first_resp");

        while (resp < 23) begin
            tick(1);
            if (last_lane >= 0) begin
                check("resp_gs", pipeGapSize[last_lane], (resp >= 20) ? 40 : 80 - 2 * resp);
                check("resp_gl", pipeGapLocation[last_lane], 112 + byte_s);
            end
        end
        check("floor_gs", pipeGapSize[last_lane], 40);
        chk_all("after_floor");

        @(negedge clk);
        frame_tick = 1;
        ded = 1;
        @(negedge clk);
        frame_tick = 0;
        chk_all("ded_tick");
        ded = 0;
        for (int k = 0; k < 5; k++) tick(0);
        chk_all("frozen");

        Reset_n = 0;
        model_reset();
        @(negedge clk);
        Reset_n = 1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) tick(1);
        check("scroll_again", pipeX[0], 650);
        @(posedge clk);
        #3 Reset_n = 0;
        model_reset();
        #1 chk_all("async_rst");
        @(negedge clk);
        Reset_n = 1;
        @(negedge clk);
        for (int k = 0; k < 671; k++) tick(1);
        check("rst_resp_x", pipeX[0], 799);
        check("rst_resp_gs", pipeGapSize[0], 78);
        check("rst_resp_gl", pipeGapLocation[0], 112 + byte_s);
        chk_all("rst_resp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
